// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the 32x32 register file: buffers results and drains one per cycle.
// Optional read bypass of still-queued results is enabled by defining WB_BYPASS_EN.
module regfile_wb_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [AW-1:0]            in_reg,
   input  logic [DW-1:0]            in_data,
   input  logic                     rf_hold,
   output logic                     RegWrite,
   output logic [AW-1:0]            writeReg,
   output logic [DW-1:0]            writeData,
   output logic [$clog2(DEPTH):0]   count,
   input  logic [AW-1:0]            rd_addr1,
   input  logic [AW-1:0]            rd_addr2,
   input  logic [DW-1:0]            rf_data1,
   input  logic [DW-1:0]            rf_data2,
   output logic [DW-1:0]            rd_data1,
   output logic [DW-1:0]            rd_data2
);

   localparam int PW = $clog2(DEPTH);

   logic [AW-1:0] reg_mem  [DEPTH];
   logic [DW-1:0] data_mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          push;
   logic          store;
   logic          pop;

   // Handshake: a request transfers at a posedge where in_valid and in_ready are both high;
   // in_ready depends only on occupancy, never on this cycle's pop or on in_valid.
   assign in_ready = (count != (PW+1)'(DEPTH));
   assign push     = in_valid & in_ready;
   assign store    = push & (in_reg != '0);
   assign pop      = RegWrite;

   always_comb begin
      RegWrite  = (count != '0) & ~rf_hold;
      writeReg  = '0;
      writeData = '0;
      if (count != '0) begin
         writeReg  = reg_mem[rd_ptr];
         writeData = data_mem[rd_ptr];
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         // Writes to $0 complete the handshake but are never queued.
         if (store) begin
            reg_mem[wr_ptr]  <= in_reg;
            data_mem[wr_ptr] <= in_data;
            wr_ptr           <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({store, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef WB_BYPASS_EN
   // Walk oldest to youngest so the youngest matching entry wins.
   always_comb begin
      logic [PW-1:0] idx;
      idx      = '0;
      rd_data1 = rf_data1;
      rd_data2 = rf_data2;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PW'(i);
         if ((PW+1)'(i) < count) begin
            if ((rd_addr1 != '0) && (reg_mem[idx] == rd_addr1)) rd_data1 = data_mem[idx];
            if ((rd_addr2 != '0) && (reg_mem[idx] == rd_addr2)) rd_data2 = data_mem[idx];
         end
      end
   end
`else
   logic unused_rd_addr;
   assign unused_rd_addr = ^{rd_addr1, rd_addr2};
   assign rd_data1       = rf_data1;
   assign rd_data2       = rf_data2;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed vector table, hand-written corner sequences and
// randomized traffic against a queue-based reference model.
module tb_regfile_wb_queue;

   localparam int DEPTH = 4;

   logic        CLK;
   logic        RESET;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_reg;
   logic [31:0] in_data;
   logic        rf_hold;
   logic        RegWrite;
   logic [4:0]  writeReg;
   logic [31:0] writeData;
   logic [2:0]  count;
   logic [4:0]  rd_addr1;
   logic [4:0]  rd_addr2;
   logic [31:0] rf_data1;
   logic [31:0] rf_data2;
   logic [31:0] rd_data1;
   logic [31:0] rd_data2;

   int n_checks = 0;
   int n_fail   = 0;

   regfile_wb_queue #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
      .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
      .in_reg(in_reg), .in_data(in_data), .rf_hold(rf_hold),
      .RegWrite(RegWrite), .writeReg(writeReg), .writeData(writeData), .count(count),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rf_data1(rf_data1), .rf_data2(rf_data2),
      .rd_data1(rd_data1), .rd_data2(rd_data2)
   );

   // clock / reset
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   typedef struct {
      logic        rst;
      logic        v;
      logic [4:0]  r;
      logic [31:0] d;
      logic        h;
      int          c;
      logic        rdy;
      logic        we;
      logic [4:0]  wr;
      logic [31:0] wd;
   } vec_t;

   vec_t tbl[17];

   // scoreboard: queued {reg, data} in arrival order
   logic [36:0] exp_q[$];

   function automatic vec_t mk(logic rst, logic v, logic [4:0] r, logic [31:0] d, logic h,
                               int c, logic rdy, logic we, logic [4:0] wr, logic [31:0] wd);
      vec_t t;
      t.rst = rst; t.v = v; t.r = r; t.d = d; t.h = h;
      t.c = c; t.rdy = rdy; t.we = we; t.wr = wr; t.wd = wd;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic drive(input logic rst, input logic v, input logic [4:0] r, input logic [31:0] d,
                        input logic h);
      RESET = rst; in_valid = v; in_reg = r; in_data = d; rf_hold = h;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [31:0] model_rd(logic [4:0] a, logic [31:0] rf);
      logic [31:0] res;
      res = rf;
`ifdef WB_BYPASS_EN
      if (a != 5'd0)
         foreach (exp_q[i])
            if (exp_q[i][36:32] == a) res = exp_q[i][31:0];
`else
      res = rf + 32'(a) * 32'd0;
`endif
      return res;
   endfunction

   task automatic model_edge();
      logic pop, acc;
      if (RESET) begin
         exp_q.delete();
      end else begin
         pop = (exp_q.size() != 0) && !rf_hold;
         acc = in_valid && (exp_q.size() != DEPTH);
         if (pop) void'(exp_q.pop_front());
         if (acc && in_reg != 5'd0) exp_q.push_back({in_reg, in_data});
      end
   endtask

   initial begin
      logic saw_we;
      logic [31:0] exp_bp;
      drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
      rd_addr1 = 5'd0; rd_addr2 = 5'd0; rf_data1 = 32'h0; rf_data2 = 32'h0;
      #1;
      tick();

      // directed table: reset, single write, fill/backpressure, $0 discard
      tbl[0]  = mk(1, 0, 0, 0,            0, 0, 1, 0, 0, 0);
      tbl[1]  = mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 1, 0, 0, 0);
      tbl[2]  = mk(0, 0, 0, 0,            0, 1, 1, 1, 5, 32'hDEADBEEF);
      tbl[3]  = mk(0, 0, 0, 0,            0, 0, 1, 0, 0, 0);
      tbl[4]  = mk(0, 1, 1, 10,           1, 0, 1, 0, 0, 0);
      tbl[5]  = mk(0, 1, 2, 11,           1, 1, 1, 0, 1, 10);
      tbl[6]  = mk(0, 1, 3, 12,           1, 2, 1, 0, 1, 10);
      tbl[7]  = mk(0, 1, 4, 13,           1, 3, 1, 0, 1, 10);
      tbl[8]  = mk(0, 1, 6, 99,           1, 4, 0, 0, 1, 10);
      tbl[9]  = mk(0, 0, 0, 0,            0, 4, 0, 1, 1, 10);
      tbl[10] = mk(0, 0, 0, 0,            0, 3, 1, 1, 2, 11);
      tbl[11] = mk(0, 0, 0, 0,            0, 2, 1, 1, 3, 12);
      tbl[12] = mk(0, 0, 0, 0,            0, 1, 1, 1, 4, 13);
      tbl[13] = mk(0, 0, 0, 0,            0, 0, 1, 0, 0, 0);
      tbl[14] = mk(0, 1, 0, 7,            0, 0, 1, 0, 0, 0);
      tbl[15] = mk(0, 0, 0, 0,            0, 0, 1, 0, 0, 0);
      tbl[16] = mk(0, 0, 0, 0,            0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 17; i++) begin
         drive(tbl[i].rst, tbl[i].v, tbl[i].r, tbl[i].d, tbl[i].h);
         #1;
         chk($sformatf("vec%0d count", i), 32'(count), 32'(tbl[i].c));
         chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
         chk($sformatf("vec%0d RegWrite", i), 32'(RegWrite), 32'(tbl[i].we));
         chk($sformatf("vec%0d writeReg", i), 32'(writeReg), 32'(tbl[i].wr));
         chk($sformatf("vec%0d writeData", i), writeData, tbl[i].wd);
         tick();
      end

      // bypass: two queued writes to $9, youngest forwarded
      drive(1'b0, 1'b1, 5'd9, 32'd100, 1'b1); tick();
      drive(1'b0, 1'b1, 5'd9, 32'd200, 1'b1); tick();
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
      rd_addr1 = 5'd9; rf_data1 = 32'd0; rd_addr2 = 5'd0; rf_data2 = 32'h5555_0000;
      #1;
`ifdef WB_BYPASS_EN
      exp_bp = 32'd200;
`else
      exp_bp = 32'd0;
`endif
      chk("bypass rd_data1", rd_data1, exp_bp);
      chk("bypass rd_data2", rd_data2, 32'h5555_0000);
      chk("bypass count", 32'(count), 32'd2);
      rd_addr1 = 5'd0;
      tick();

      // reset mid-operation: 3 entries pending plus an incoming request
      drive(1'b0, 1'b1, 5'd3, 32'd33, 1'b1); tick();
      drive(1'b1, 1'b1, 5'd7, 32'd77, 1'b1);
      #1;
      chk("pre-reset count", 32'(count), 32'd3);
      tick();
      drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
      #1;
      chk("mid-reset count", 32'(count), 32'd0);
      chk("mid-reset RegWrite", 32'(RegWrite), 32'd0);
      chk("mid-reset writeReg", 32'(writeReg), 32'd0);
      saw_we = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         saw_we = saw_we | RegWrite;
      end
      chk("post-reset no write", 32'(saw_we), 32'd0);

      // randomized traffic against the queue model
      drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
      #1;
      tick();
      model_edge();
      for (int cyc = 0; cyc < 800; cyc++) begin
         drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 60),
               5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 99) < 35));
         rd_addr1 = 5'($urandom_range(0, 7));
         rd_addr2 = 5'($urandom_range(0, 7));
         rf_data1 = $urandom;
         rf_data2 = $urandom;
         #1;
         chk($sformatf("rnd%0d count", cyc), 32'(count), 32'(exp_q.size()));
         chk($sformatf("rnd%0d in_ready", cyc), 32'(in_ready), 32'(exp_q.size() != DEPTH));
         chk($sformatf("rnd%0d RegWrite", cyc), 32'(RegWrite),
             32'((exp_q.size() != 0) && !rf_hold));
         chk($sformatf("rnd%0d writeReg", cyc), 32'(writeReg),
             (exp_q.size() != 0) ? 32'(exp_q[0][36:32]) : 32'd0);
         chk($sformatf("rnd%0d writeData", cyc), writeData,
             (exp_q.size() != 0) ? exp_q[0][31:0] : 32'd0);
         chk($sformatf("rnd%0d rd_data1", cyc), rd_data1, model_rd(rd_addr1, rf_data1));
         chk($sformatf("rnd%0d rd_data2", cyc), rd_data2, model_rd(rd_addr2, rf_data2));
         @(posedge CLK);
         model_edge();
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
